// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor built from SEG-bit ripple segments,
// one register stage per segment, with carry-out and signed overflow.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || SEG < 1) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a positive multiple of SEG");
    end

    // Subtraction is a + ~b + ~ci, so borrow-in maps onto an inverted carry-in.
    logic [WIDTH-1:0] beff;
    logic             cin0;
    assign beff = sub ? ~b : b;
    assign cin0 = sub ? ~ci : ci;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int LO_W = gi * SEG;
        localparam int HI_W = (NSEG - 1 - gi) * SEG;

        logic [SEG-1:0]       op_a;
        logic [SEG-1:0]       op_b;
        logic                 carry_in;
        logic                 valid_in;
        logic [SEG:0]         seg_sum;
        logic [LO_W+SEG-1:0]  res_next;
        logic [LO_W+SEG-1:0]  res_reg;
        logic                 carry_reg;
        logic                 valid_reg;

        assign seg_sum = {1'b0, op_a} + {1'b0, op_b} + {{SEG{1'b0}}, carry_in};

        if (gi == 0) begin : g_src
            assign op_a     = a[SEG-1:0];
            assign op_b     = beff[SEG-1:0];
            assign carry_in = cin0;
            assign valid_in = in_valid;
            assign res_next = seg_sum[SEG-1:0];
        end else begin : g_src
            assign op_a     = g_stage[gi-1].g_skew.a_hi_reg[SEG-1:0];
            assign op_b     = g_stage[gi-1].g_skew.b_hi_reg[SEG-1:0];
            assign carry_in = g_stage[gi-1].carry_reg;
            assign valid_in = g_stage[gi-1].valid_reg;
            // Lower result segments ride along so the whole word emerges together.
            assign res_next = {seg_sum[SEG-1:0], g_stage[gi-1].res_reg};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                res_reg   <= '0;
                carry_reg <= 1'b0;
                valid_reg <= 1'b0;
            end else if (en) begin
                res_reg   <= res_next;
                carry_reg <= seg_sum[SEG];
                valid_reg <= valid_in;
            end
        end

        // Operand segments not yet consumed are delayed to meet their carry.
        if (gi < NSEG - 1) begin : g_skew
            logic [HI_W-1:0] a_hi_next;
            logic [HI_W-1:0] b_hi_next;
            logic [HI_W-1:0] a_hi_reg;
            logic [HI_W-1:0] b_hi_reg;

            if (gi == 0) begin : g_hi_src
                assign a_hi_next = a[WIDTH-1:SEG];
                assign b_hi_next = beff[WIDTH-1:SEG];
            end else begin : g_hi_src
                assign a_hi_next = g_stage[gi-1].g_skew.a_hi_reg[HI_W+SEG-1:SEG];
                assign b_hi_next = g_stage[gi-1].g_skew.b_hi_reg[HI_W+SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi_reg <= '0;
                    b_hi_reg <= '0;
                end else if (en) begin
                    a_hi_reg <= a_hi_next;
                    b_hi_reg <= b_hi_next;
                end
            end
        end
    end

    // Overflow uses the operand MSBs as they arrive at the final segment.
    logic ovf_next;
    logic ovf_reg;
    assign ovf_next = (g_stage[NSEG-1].op_a[SEG-1] == g_stage[NSEG-1].op_b[SEG-1]) &&
                      (g_stage[NSEG-1].seg_sum[SEG-1] != g_stage[NSEG-1].op_a[SEG-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (en) begin
            ovf_reg <= ovf_next;
        end
    end

    assign sum       = g_stage[NSEG-1].res_reg;
    assign co        = g_stage[NSEG-1].carry_reg;
    assign out_valid = g_stage[NSEG-1].valid_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, SEG=4): expected results
// are queued at capture and matched against the output NSEG enabled edges later.
module tb_pipelined_addsub;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
        int               due;
    } exp_t;

    exp_t q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   adv_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference computed with plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input logic s);
        exp_t e;
        int   ur;
        int   sr;
        if (!s) begin
            ur   = int'(x) + int'(y) + int'(c);
            sr   = int'($signed(x)) + int'($signed(y)) + int'(c);
            e.co = (ur > 65535);
        end else begin
            ur   = int'(x) - int'(y) - int'(c);
            sr   = int'($signed(x)) - int'($signed(y)) - int'(c);
            e.co = (ur >= 0);
        end
        e.sum = ur[WIDTH-1:0];
        e.ovf = (sr > 32767) || (sr < -32768);
        e.a   = x;
        e.b   = y;
        e.sub = s;
        e.due = 0;
        return e;
    endfunction

    // Monitor: samples controls at the edge and outputs 1 time unit later.
    logic             s_rst, s_en, s_iv, s_ci, s_sub;
    logic [WIDTH-1:0] s_a, s_b;
    logic             exp_valid = 1'b0;
    logic [WIDTH-1:0] exp_sum   = '0;
    exp_t             m_e;

    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst; s_en = en; s_iv = in_valid;
            s_a = a; s_b = b; s_ci = ci; s_sub = sub;
            #1;
            if (s_rst) begin
                q.delete();
                exp_valid = 1'b0;
                check("rst_out_valid", out_valid, 0);
            end else if (!s_en) begin
                check("stall_out_valid", out_valid, exp_valid);
                if (exp_valid) check("stall_sum", sum, exp_sum);
            end else begin
                adv_cnt++;
                if (s_iv) begin
                    m_e = model(s_a, s_b, s_ci, s_sub);
                    m_e.due = adv_cnt + NSEG - 1;
                    q.push_back(m_e);
                end
                if (q.size() > 0 && q[0].due == adv_cnt) begin
                    m_e = q.pop_front();
                    check("out_valid", out_valid, 1);
                    check("sum", sum, m_e.sum);
                    check("co", co, m_e.co);
                    check("ovf", ovf, m_e.ovf);
                    exp_valid = 1'b1;
                    exp_sum   = m_e.sum;
                    $display("op %s a=%h b=%h -> sum=%h co=%b ovf=%b (exp %h %b %b)",
                             m_e.sub ? "sub" : "add", m_e.a, m_e.b, sum, co, ovf,
                             m_e.sum, m_e.co, m_e.ovf);
                end else begin
                    check("bubble_out_valid", out_valid, 0);
                    exp_valid = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic e, input logic iv, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic c, input logic s);
        en = e; in_valid = iv; a = x; b = y; ci = c; sub = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    logic [WIDTH-1:0] rx, ry;

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sum", sum, 0);
        check("reset_co", co, 0);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;

        // Directed arithmetic cases, back to back.
        drive(1, 1, 16'h1234, 16'h4321, 0, 0);
        drive(1, 1, 16'hFFFF, 16'h0001, 0, 0);
        drive(1, 1, 16'h7FFF, 16'h0001, 0, 0);
        drive(1, 1, 16'h0005, 16'h0007, 0, 1);
        drive(1, 1, 16'h8000, 16'h0001, 0, 1);
        drive(1, 1, 16'hFFFF, 16'hFFFF, 1, 0);
        drive(1, 1, 16'h0000, 16'h0000, 1, 1);
        idle(6);

        // Stream with one bubble between the 2nd and 3rd operations.
        drive(1, 1, 16'h0001, 16'h0001, 0, 0);
        drive(1, 1, 16'h00FF, 16'h0001, 0, 0);
        idle(1);
        drive(1, 1, 16'h0FFF, 16'h0001, 0, 0);
        idle(6);

        // Stall with three in flight; offered operations during stall are ignored.
        drive(1, 1, 16'h1111, 16'h2222, 0, 0);
        drive(1, 1, 16'hABCD, 16'h1234, 1, 1);
        drive(1, 1, 16'h8000, 16'h8000, 0, 0);
        drive(0, 1, 16'hDEAD, 16'hBEEF, 0, 0);
        drive(0, 1, 16'hCAFE, 16'hF00D, 1, 1);
        idle(6);

        // Reset with two in flight, reset coinciding with an offered operation.
        drive(1, 1, 16'h0101, 16'h0202, 0, 0);
        drive(1, 1, 16'h0303, 16'h0404, 0, 0);
        rst = 1'b1;
        drive(1, 1, 16'h5555, 16'h5555, 0, 0);
        rst = 1'b0;
        idle(4);
        drive(1, 1, 16'h2468, 16'h1357, 0, 0);
        idle(6);

        // Random traffic with random stalls, bubbles and carry-chain corners.
        for (int i = 0; i < 300; i++) begin
            rx = 16'($urandom());
            ry = 16'($urandom());
            if ($urandom_range(0, 7) == 0) rx = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) ry = 16'h0001;
            if ($urandom_range(0, 9) == 0) rx = 16'h8000;
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, rx, ry,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        en = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        check("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
